// File: rtl/picosoc_bus_arbiter.sv
// Two-master round-robin arbiter for the PicoSoC native memory bus.
// The grant is held until the slave completes, the master withdraws, or the watchdog expires.
module picosoc_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err,
  input  logic        err_clear
);

  localparam int WDOG_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT_CYCLES);
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              last_owner, last_owner_nxt;
  logic [WDOG_W-1:0] wdog, wdog_nxt;
  logic              cur_valid;
  logic              done;
  logic              expire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_owner  <= 1'b1;
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      wdog       <= wdog_nxt;
      if (expire)
        timeout_err <= 1'b1;
      else if (err_clear)
        timeout_err <= 1'b0;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    wdog_nxt       = '0;
    cur_valid      = 1'b0;
    s_instr        = 1'b0;
    s_wstrb        = '0;
    s_addr         = '0;
    s_wdata        = '0;

    case (state)
      GRANT0: begin
        cur_valid = m0_valid;
        s_instr   = m0_instr;
        s_wstrb   = m0_wstrb;
        s_addr    = m0_addr;
        s_wdata   = m0_wdata;
      end
      GRANT1: begin
        cur_valid = m1_valid;
        s_wstrb   = m1_wstrb;
        s_addr    = m1_addr;
        s_wdata   = m1_wdata;
      end
      default: ;
    endcase

    // A late s_ready in the expiry cycle wins over the watchdog.
    done    = cur_valid && s_ready;
    expire  = WDOG_EN && cur_valid && !s_ready && (wdog == WDOG_MAX);
    s_valid = cur_valid && !expire;

    m0_ready = (state == GRANT0) && (done || expire);
    m1_ready = (state == GRANT1) && (done || expire);
    m0_rdata = ((state == GRANT0) && done) ? s_rdata : '0;
    m1_rdata = ((state == GRANT1) && done) ? s_rdata : '0;
    grant    = {state == GRANT1, state == GRANT0};

    case (state)
      IDLE: begin
        if (m0_valid && (!m1_valid || last_owner))
          state_nxt = GRANT0;
        else if (m1_valid)
          state_nxt = GRANT1;
      end
      default: begin
        if (!cur_valid) begin
          state_nxt = IDLE;
        end else if (done || expire) begin
          state_nxt      = IDLE;
          last_owner_nxt = (state == GRANT1);
        end else if (WDOG_EN) begin
          wdog_nxt = wdog + 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_picosoc_bus_arbiter.sv
// Directed bench for picosoc_bus_arbiter: a cycle-count owner model checked every cycle,
// plus hand-computed literal expectations per scenario.
module tb_picosoc_bus_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_instr;
  logic [3:0]  m0_wstrb;
  logic [31:0] m0_addr, m0_wdata;
  logic        m0_ready;
  logic [31:0] m0_rdata;
  logic        m1_valid;
  logic [3:0]  m1_wstrb;
  logic [31:0] m1_addr, m1_wdata;
  logic        m1_ready;
  logic [31:0] m1_rdata;
  logic        s_valid, s_instr;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic [1:0]  grant;
  logic        timeout_err;
  logic        err_clear;

  int n_tests = 0;
  int n_fail  = 0;

  picosoc_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_wstrb(m0_wstrb),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_wstrb(s_wstrb), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  // Model: who owns the bus (-1 none), who was served last, cycle the tenure began.
  typedef struct {
    int owner;
    int last;
    int start;
    bit err;
  } mstate_t;

  mstate_t ms;
  int      cyc;

  function automatic mstate_t model_next(mstate_t s, int c);
    mstate_t n = s;
    logic vx;
    logic tmo;
    tmo = 1'b0;
    if (s.owner < 0) begin
      if (m0_valid && (!m1_valid || s.last == 1)) begin
        n.owner = 0;
        n.start = c + 1;
      end else if (m1_valid) begin
        n.owner = 1;
        n.start = c + 1;
      end
    end else begin
      vx  = (s.owner == 0) ? m0_valid : m1_valid;
      tmo = vx && !s_ready && (TMO != 0) && ((c - s.start) == TMO);
      if (!vx) begin
        n.owner = -1;
      end else if (s_ready || tmo) begin
        n.owner = -1;
        n.last  = s.owner;
      end
    end
    if (tmo)
      n.err = 1'b1;
    else if (err_clear)
      n.err = 1'b0;
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ms  <= '{owner: -1, last: 1, start: 0, err: 1'b0};
      cyc <= 0;
    end else begin
      ms  <= model_next(ms, cyc);
      cyc <= cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int   own;
    logic vx, tmo, done;
    own  = ms.owner;
    vx   = (own == 0) ? m0_valid : (own == 1) ? m1_valid : 1'b0;
    tmo  = vx && !s_ready && (TMO != 0) && ((cyc - ms.start) == TMO);
    done = vx && s_ready;
    chk("grant",       32'(grant), (own == 0) ? 32'd1 : (own == 1) ? 32'd2 : 32'd0);
    chk("s_valid",     32'(s_valid), 32'(vx && !tmo));
    chk("s_instr",     32'(s_instr), 32'((own == 0) && m0_instr));
    chk("s_wstrb",     32'(s_wstrb), (own == 0) ? 32'(m0_wstrb) : (own == 1) ? 32'(m1_wstrb) : 32'd0);
    chk("s_addr",      s_addr,  (own == 0) ? m0_addr  : (own == 1) ? m1_addr  : 32'd0);
    chk("s_wdata",     s_wdata, (own == 0) ? m0_wdata : (own == 1) ? m1_wdata : 32'd0);
    chk("m0_ready",    32'(m0_ready), 32'((own == 0) && (done || tmo)));
    chk("m0_rdata",    m0_rdata, ((own == 0) && done) ? s_rdata : 32'd0);
    chk("m1_ready",    32'(m1_ready), 32'((own == 1) && (done || tmo)));
    chk("m1_rdata",    m1_rdata, ((own == 1) && done) ? s_rdata : 32'd0);
    chk("timeout_err", 32'(timeout_err), 32'(ms.err));
  endtask

  task automatic sample();
    @(negedge clk);
    compare_all();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_rr [8] = '{0, 1, 0, 2, 0, 1, 0, 2};
  int pulses;

  initial begin
    reset = 1'b1;
    m0_valid = 0; m0_instr = 0; m0_wstrb = 0; m0_addr = 0; m0_wdata = 0;
    m1_valid = 0; m1_wstrb = 0; m1_addr = 0; m1_wdata = 0;
    s_ready = 1'b1; s_rdata = 32'hFFFF_FFFF; err_clear = 0;
    tick();
    tick();

    // Reset state
    sample();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    tick();
    reset = 1'b0;

    // Simultaneous requests from reset: strict alternation, m0 first
    m0_valid = 1; m0_instr = 1; m0_addr = 32'h0000_0100; m0_wstrb = 0; m0_wdata = 32'h1111_2222;
    m1_valid = 1; m1_addr = 32'h2000_0040; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'hF;
    s_ready = 1; s_rdata = 32'hA5A5_0001;
    for (int k = 0; k < 8; k++) begin
      sample();
      chk("rr_grant", 32'(grant), 32'(exp_rr[k]));
      if (k == 3 || k == 7) begin
        chk("rr_m1_addr", s_addr, 32'h2000_0040);
        chk("rr_m1_wdata", s_wdata, 32'hCAFE_F00D);
        chk("rr_m1_ready", 32'(m1_ready), 32'd1);
        chk("rr_s_instr", 32'(s_instr), 32'd0);
      end
      tick();
    end
    m0_valid = 0; m1_valid = 0; s_ready = 0; m0_instr = 0;
    sample();
    tick();

    // m0 read with a zero-wait slave
    m0_valid = 1; m0_instr = 1; m0_addr = 32'h0000_0010; m0_wstrb = 0;
    s_ready = 1; s_rdata = 32'h1234_5678;
    sample();
    chk("rd_idle_grant", 32'(grant), 32'd0);
    chk("rd_idle_ready", 32'(m0_ready), 32'd0);
    tick();
    sample();
    chk("rd_grant", 32'(grant), 32'd1);
    chk("rd_s_valid", 32'(s_valid), 32'd1);
    chk("rd_s_addr", s_addr, 32'h0000_0010);
    chk("rd_s_instr", 32'(s_instr), 32'd1);
    chk("rd_m0_ready", 32'(m0_ready), 32'd1);
    chk("rd_m0_rdata", m0_rdata, 32'h1234_5678);
    tick();
    m0_valid = 0; m0_instr = 0; s_ready = 0;
    sample();
    chk("rd_after_grant", 32'(grant), 32'd0);
    tick();

    // m1 write with three wait states
    m1_valid = 1; m1_wstrb = 4'b0011; m1_addr = 32'h3000_0008; m1_wdata = 32'h0000_BEEF;
    s_ready = 0; s_rdata = 32'h0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) s_ready = 1;
      if (k == 5) begin m1_valid = 0; s_ready = 0; end
      sample();
      pulses += int'(m1_ready);
      if (k >= 1 && k <= 4) begin
        chk("wr_s_wstrb", 32'(s_wstrb), 32'd3);
        chk("wr_grant", 32'(grant), 32'd2);
        chk("wr_m0_ready", 32'(m0_ready), 32'd0);
      end
      tick();
    end
    chk("wr_m1_ready_pulses", 32'(pulses), 32'd1);

    // Watchdog with a slave that never answers
    m0_valid = 1; m0_addr = 32'h0000_0040; m0_wstrb = 0;
    s_ready = 0; s_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 12; k++) begin
      err_clear = (k == 11);
      sample();
      if (k == 5 || k == 11) begin
        chk("wd_m0_ready", 32'(m0_ready), 32'd1);
        chk("wd_m0_rdata", m0_rdata, 32'd0);
        chk("wd_s_valid", 32'(s_valid), 32'd0);
      end else if (k == 0 || k == 6) begin
        chk("wd_idle_grant", 32'(grant), 32'd0);
      end else begin
        chk("wd_wait_ready", 32'(m0_ready), 32'd0);
        chk("wd_wait_s_valid", 32'(s_valid), 32'd1);
      end
      if (k == 0) chk("wd_err_before", 32'(timeout_err), 32'd0);
      if (k == 6) chk("wd_err_set", 32'(timeout_err), 32'd1);
      tick();
    end
    m0_valid = 0; err_clear = 1;
    sample();
    chk("wd_set_beats_clear", 32'(timeout_err), 32'd1);
    tick();
    err_clear = 0;
    sample();
    chk("wd_cleared", 32'(timeout_err), 32'd0);
    tick();

    // Reset during a waiting m1 transaction
    m1_valid = 1; m1_wstrb = 0; m1_addr = 32'h0000_0500; s_ready = 0; s_rdata = 32'h0BAD_0BAD;
    sample();
    tick();
    sample();
    chk("rs_grant_before", 32'(grant), 32'd2);
    tick();
    sample();
    chk("rs_s_valid_before", 32'(s_valid), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rs_s_valid", 32'(s_valid), 32'd0);
    chk("rs_grant", 32'(grant), 32'd0);
    chk("rs_m1_ready", 32'(m1_ready), 32'd0);
    tick();
    sample();
    tick();
    reset = 1'b0;
    sample();
    chk("rs_idle_after", 32'(grant), 32'd0);
    tick();
    s_ready = 1; s_rdata = 32'h7777_0001;
    sample();
    chk("rs_regrant", 32'(grant), 32'd2);
    chk("rs_m1_ready_after", 32'(m1_ready), 32'd1);
    chk("rs_m1_rdata_after", m1_rdata, 32'h7777_0001);
    tick();
    m1_valid = 0; s_ready = 0;
    sample();
    tick();

    // m0 withdraws mid-grant while m1 is pending
    m0_valid = 1; m0_addr = 32'h0000_0600; m1_valid = 0; s_ready = 0;
    sample();
    chk("wdr_idle", 32'(grant), 32'd0);
    tick();
    m1_valid = 1; m1_addr = 32'h0000_0700;
    sample();
    chk("wdr_g0", 32'(grant), 32'd1);
    tick();
    m0_valid = 0;
    sample();
    chk("wdr_grant", 32'(grant), 32'd1);
    chk("wdr_m0_ready", 32'(m0_ready), 32'd0);
    chk("wdr_s_valid", 32'(s_valid), 32'd0);
    tick();
    sample();
    chk("wdr_back_idle", 32'(grant), 32'd0);
    tick();
    s_ready = 1; s_rdata = 32'h0000_0707;
    sample();
    chk("wdr_m1_grant", 32'(grant), 32'd2);
    chk("wdr_m1_ready", 32'(m1_ready), 32'd1);
    tick();
    m1_valid = 0; s_ready = 0;
    sample();
    chk("wdr_final_idle", 32'(grant), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
